// File: rtl/riscv_v_swizzle_pipe_if.sv
// Valid/ready bundle for the element-reversal pipe: input beat side,
// output beat side and the overflow pulse.
interface riscv_v_swizzle_pipe_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_OSIZES = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [NUM_OSIZES-1:0] in_osize_vec;
    logic [1:0]            in_mode;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  err;

    // Producer of input beats and consumer of output beats
    modport master (
        output in_valid, in_data, in_osize_vec, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, err
    );

    // The swizzle pipe itself
    modport slave (
        input  in_valid, in_data, in_osize_vec, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, err
    );
endinterface

// File: rtl/riscv_v_swizzle_pipe.sv
// Pipelined element-reversal unit. Modes: 00/11 pass, 01 reverse elements
// within a beat, 10 buffer a register group and replay it in reverse beat
// order with each beat element-reversed.
module riscv_v_swizzle_pipe #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_OSIZES = 5,
    parameter int unsigned MAX_BEATS  = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    riscv_v_swizzle_pipe_if.slave bus
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = $clog2(MAX_BEATS);
    localparam int unsigned CNT_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_OSIZES-1:0] grp_osize;
    logic [DATA_WIDTH-1:0] grp_buf [MAX_BEATS];
    logic                  ready_en;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                  out_free;
    logic                  in_ready_c;
    logic                  in_fire;
    logic                  mode_rev;
    logic                  mode_grp;
    logic                  cnt_is_one;
    logic                  cnt_at_cap;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    // Every element size is a power-of-two number of bytes, so the reversal
    // is done byte by byte: byte j of element j/eb lands in the mirrored
    // element at the same offset. Selected sizes OR together.
    function automatic logic [DATA_WIDTH-1:0] swizzle(
        input logic [DATA_WIDTH-1:0] d,
        input logic [NUM_OSIZES-1:0] osize
    );
        logic [DATA_WIDTH-1:0] r;
        int unsigned           eb;
        int unsigned           dst;
        r = '0;
        for (int unsigned k = 0; k < NUM_OSIZES; k++) begin
            if (osize[k]) begin
                eb = 1 << k;
                for (int unsigned j = 0; j < NUM_BYTES; j++) begin
                    dst = NUM_BYTES - eb * (j / eb + 1) + j % eb;
                    r[dst*8 +: 8] = r[dst*8 +: 8] | d[j*8 +: 8];
                end
            end
        end
        return r;
    endfunction

    // Handshake decode and buffer indexing
    always_comb begin
        mode_rev   = (bus.in_mode == 2'b01);
        mode_grp   = (bus.in_mode == 2'b10);
        out_free   = !out_valid_q || bus.out_ready;
        case (state)
            IDLE:    in_ready_c = ready_en && out_free;
            FILL:    in_ready_c = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
        in_fire    = bus.in_valid && in_ready_c;
        cnt_is_one = (cnt == CNT_W'(1));
        cnt_at_cap = (cnt == CNT_W'(MAX_BEATS - 1));
        wr_idx     = cnt[IDX_W-1:0];
        rd_idx     = IDX_W'(cnt - CNT_W'(1));
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;

    // Group beat storage: slot 0 on the opening beat, slot cnt while filling
    always_ff @(posedge clk) begin
        if (in_fire && state == IDLE && mode_grp) begin
            grp_buf[0] <= bus.in_data;
        end else if (in_fire && state == FILL) begin
            grp_buf[wr_idx] <= bus.in_data;
        end
    end

    // Control FSM and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            grp_osize   <= '0;
            ready_en    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            err_q    <= 1'b0;
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (mode_grp) begin
                            grp_osize <= bus.in_osize_vec;
                            cnt       <= CNT_W'(1);
                            state     <= bus.in_last ? DRAIN : FILL;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= mode_rev ? swizzle(bus.in_data, bus.in_osize_vec)
                                                    : bus.in_data;
                            out_last_q  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_fire) begin
                        cnt <= cnt + CNT_W'(1);
                        if (bus.in_last) begin
                            state <= DRAIN;
                        end else if (cnt_at_cap) begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= swizzle(grp_buf[rd_idx], grp_osize);
                        out_last_q  <= cnt_is_one;
                        cnt         <= cnt - CNT_W'(1);
                        if (cnt_is_one) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_v_swizzle_pipe.sv
// Self-checking bench for riscv_v_swizzle_pipe: table vectors, hand-written
// group/backpressure/overflow/reset sequences, then randomized traffic
// checked against a beat-level reference model.
module tb_riscv_v_swizzle_pipe;
    localparam int unsigned DW = 128;
    localparam int unsigned NO = 5;
    localparam int unsigned MB = 8;

    typedef struct {
        logic [1:0]    mode;
        logic [NO-1:0] os;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [NO-1:0] os;
        logic [1:0]    mode;
        logic          last;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    riscv_v_swizzle_pipe_if #(.DATA_WIDTH(DW), .NUM_OSIZES(NO)) bus ();

    riscv_v_swizzle_pipe #(
        .DATA_WIDTH(DW),
        .NUM_OSIZES(NO),
        .MAX_BEATS (MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    vec_t          vecs[9];
    beat_t         exp_q[$];
    beat_t         eb;
    stim_t         stim_q[$];
    stim_t         cur;
    logic [DW-1:0] grp_q[$];
    logic [NO-1:0] grp_os;
    logic          in_grp;
    logic          err_pend;
    logic [DW-1:0] dv[8];
    logic [DW-1:0] g_exp[3];

    localparam logic [DW-1:0] PA = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [DW-1:0] PB = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [DW-1:0] PC = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element reversal from the definition: cut into W-bit elements,
    // place element i at slot n-1-i, OR over every selected size.
    function automatic logic [DW-1:0] ref_sw(input logic [DW-1:0] d, input logic [NO-1:0] os);
        logic [DW-1:0] r;
        logic [DW-1:0] mask;
        int            w;
        int            n;
        r = '0;
        for (int k = 0; k < int'(NO); k++) begin
            if (os[k]) begin
                w    = 8 << k;
                n    = DW / w;
                mask = {DW{1'b1}} >> (DW - w);
                for (int i = 0; i < n; i++) begin
                    r = r | (((d >> (i * w)) & mask) << ((n - 1 - i) * w));
                end
            end
        end
        return r;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic [NO-1:0] os,
                             input logic [1:0] md, input logic lst);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_osize_vec = os;
        bus.in_mode      = md;
        bus.in_last      = lst;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 100 cycles");
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Consume exp_q beats with a per-cycle out_ready pattern, checking order,
    // out_last and hold-while-stalled, then confirm nothing further appears.
    task automatic drain_check(input string tag, input logic [15:0] pat);
        int            cyc;
        logic          stalled;
        logic [DW-1:0] held;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = pat[cyc % 16];
            #1;
            if (stalled) begin
                chk({tag, "_hold_valid"}, bus.out_valid, 1);
                chk({tag, "_hold_data"}, bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                eb = exp_q.pop_front();
                chk({tag, "_data"}, bus.out_data, eb.data);
                chk({tag, "_last"}, bus.out_last, eb.last);
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            cyc++;
        end
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk({tag, "_no_extra"}, bus.out_valid, 0);
        end
    endtask

    task automatic model_accept(input stim_t s);
        if (!in_grp) begin
            if (s.mode == 2'b10) begin
                grp_q.delete();
                grp_q.push_back(s.data);
                grp_os = s.os;
                in_grp = 1'b1;
            end else begin
                exp_q.push_back('{(s.mode == 2'b01) ? ref_sw(s.data, s.os) : s.data, 1'b1});
            end
        end else begin
            grp_q.push_back(s.data);
        end
        if (in_grp && (s.last || grp_q.size() == MB)) begin
            if (!s.last) err_pend = 1'b1;
            for (int i = grp_q.size() - 1; i >= 0; i--) begin
                exp_q.push_back('{ref_sw(grp_q[i], grp_os), (i == 0)});
            end
            in_grp = 1'b0;
        end
    endtask

    initial begin
        logic          stalled;
        logic [DW-1:0] held;
        int            cyc;
        logic          have_cur;

        vecs[0] = '{2'b01, 5'b00001, PA, 128'h00010203_04050607_08090A0B_0C0D0E0F};
        vecs[1] = '{2'b01, 5'b00100, PA, 128'h03020100_07060504_0B0A0908_0F0E0D0C};
        vecs[2] = '{2'b01, 5'b00000, PA, '0};
        vecs[3] = '{2'b00, 5'b00001, PA, PA};
        vecs[4] = '{2'b11, 5'b00001, PA, PA};
        vecs[5] = '{2'b01, 5'b01000, PA, 128'h07060504_03020100_0F0E0D0C_0B0A0908};
        vecs[6] = '{2'b01, 5'b00010, PA, 128'h01000302_05040706_09080B0A_0D0C0F0E};
        vecs[7] = '{2'b01, 5'b00011, PA, 128'h01010303_05050707_09090B0B_0D0D0F0F};
        vecs[8] = '{2'b01, 5'b10000, PA, PA};

        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_osize_vec = '0;
        bus.in_mode      = 2'b00;
        bus.in_last      = 1'b0;
        bus.out_ready    = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Single-beat table, latency 1
        for (int v = 0; v < 9; v++) begin
            send_beat(vecs[v].din, vecs[v].os, vecs[v].mode, 1'b0);
            chk($sformatf("vec%0d_valid", v), bus.out_valid, 1);
            chk($sformatf("vec%0d_data", v), bus.out_data, vecs[v].exp);
            chk($sformatf("vec%0d_last", v), bus.out_last, 1);
        end

        // Three-beat group, exact drain timing
        g_exp[0] = 128'h20212223_24252627_28292A2B_2C2D2E2F;
        g_exp[1] = 128'h10111213_14151617_18191A1B_1C1D1E1F;
        g_exp[2] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        bus.out_ready = 1'b1;
        send_beat(PA, 5'b00001, 2'b10, 1'b0);
        send_beat(PB, 5'b00100, 2'b01, 1'b0);
        send_beat(PC, 5'b10000, 2'b00, 1'b1);
        chk("grp_gap_valid", bus.out_valid, 0);
        chk("grp_gap_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("grp_b%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("grp_b%0d_data", i), bus.out_data, g_exp[i]);
            chk($sformatf("grp_b%0d_last", i), bus.out_last, (i == 2));
            if (i < 2) chk($sformatf("grp_b%0d_in_ready", i), bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        chk("grp_done_valid", bus.out_valid, 0);

        // Same group under backpressure
        send_beat(PA, 5'b00001, 2'b10, 1'b0);
        send_beat(PB, 5'b00001, 2'b10, 1'b0);
        send_beat(PC, 5'b00001, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back('{g_exp[i], (i == 2)});
        drain_check("bp", 16'hFFD9);

        // Overflow: MAX_BEATS beats and no in_last
        for (int i = 0; i < int'(MB); i++) begin
            dv[i] = {$urandom, $urandom, $urandom, $urandom};
            send_beat(dv[i], 5'b00001, (i == 0) ? 2'b10 : 2'($urandom_range(0, 3)), 1'b0);
        end
        chk("ovf_err_pulse", bus.err, 1);
        chk("ovf_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("ovf_err_clear", bus.err, 0);
        for (int i = int'(MB) - 1; i >= 0; i--) exp_q.push_back('{ref_sw(dv[i], 5'b00001), (i == 0)});
        drain_check("ovf", 16'hFFFF);

        // Reset during drain discards the group
        for (int i = 0; i < 4; i++) begin
            dv[i] = {$urandom, $urandom, $urandom, $urandom};
            send_beat(dv[i], 5'b00001, 2'b10, (i == 3));
        end
        @(posedge clk);
        #1;
        chk("rd_first_data", bus.out_data, ref_sw(dv[3], 5'b00001));
        @(posedge clk);
        #1;
        chk("rd_second_data", bus.out_data, ref_sw(dv[2], 5'b00001));
        rst_n = 1'b0;
        #1;
        chk("rd_rst_valid", bus.out_valid, 0);
        chk("rd_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("rd_no_stale", bus.out_valid, 0);
        end
        send_beat(PA, 5'b00001, 2'b01, 1'b0);
        chk("rd_after_valid", bus.out_valid, 1);
        chk("rd_after_data", bus.out_data, g_exp[2]);
        chk("rd_after_last", bus.out_last, 1);
        @(posedge clk);
        #1;
        chk("rd_after_empty", bus.out_valid, 0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 120; t++) begin
            int m;
            int len;
            m = $urandom_range(0, 3);
            if (m == 2) begin
                len = $urandom_range(1, 10);
                for (int b = 0; b < len; b++) begin
                    stim_q.push_back('{{$urandom, $urandom, $urandom, $urandom},
                                       ($urandom_range(0, 3) != 0) ? NO'(1 << $urandom_range(0, NO - 1))
                                                                   : NO'($urandom),
                                       (b == 0) ? 2'b10 : 2'($urandom_range(0, 3)),
                                       (b == len - 1)});
                end
            end else begin
                stim_q.push_back('{{$urandom, $urandom, $urandom, $urandom},
                                   ($urandom_range(0, 3) != 0) ? NO'(1 << $urandom_range(0, NO - 1))
                                                               : NO'($urandom),
                                   2'(m), 1'($urandom_range(0, 1))});
            end
        end
        exp_q.delete();
        in_grp   = 1'b0;
        err_pend = 1'b0;
        have_cur = 1'b0;
        stalled  = 1'b0;
        held     = '0;
        cur      = '{'0, '0, 2'b00, 1'b0};
        for (cyc = 0; cyc < 20000; cyc++) begin
            if (stim_q.size() == 0 && !have_cur && exp_q.size() == 0 && !in_grp && !err_pend) break;
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!have_cur && stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                cur      = stim_q.pop_front();
                have_cur = 1'b1;
            end
            bus.in_valid     = have_cur;
            bus.in_data      = cur.data;
            bus.in_osize_vec = cur.os;
            bus.in_mode      = cur.mode;
            bus.in_last      = cur.last;
            #1;
            chk("rnd_err", bus.err, err_pend);
            err_pend = 1'b0;
            if (stalled) begin
                chk("rnd_hold_valid", bus.out_valid, 1);
                chk("rnd_hold_data", bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", bus.out_valid, 0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("rnd_data", bus.out_data, eb.data);
                    chk("rnd_last", bus.out_last, eb.last);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                model_accept(cur);
                have_cur = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        chk("rnd_stim_left", stim_q.size() + (have_cur ? 1 : 0), 0);
        chk("rnd_beats_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_v_swizzle_pipe.md
# riscv_v_swizzle_pipe

Pipelined, handshaked element-reversal unit for the vector datapath. It generalises combinational element swizzling in two ways: data width and supported element sizes are parameters, and it adds a register-group mode. In that mode the beats of an LMUL>1 group are buffered and replayed in reverse beat order, with elements reversed inside each beat, so the whole group is reversed end to end. It sits between the vector register-file read port and the permute/ALU stage, behind valid/ready on both sides.

## Interface
- DATA_WIDTH, 128, beat width in bits; multiple of 8·2^(NUM_OSIZES-1)
- NUM_OSIZES, 5, number of element sizes; index k selects 8·2^k-bit elements
- MAX_BEATS, 8, maximum beats per register group (power of two, ≥2)
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_WIDTH  input beat
- in_osize_vec  in  NUM_OSIZES  element-size select, one-hot expected
- in_mode  in  2  00 pass, 01 reverse within beat, 10 reverse register group, 11 treated as 00
- in_last  in  1  last beat of group (mode 10 only)
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat taken when out_valid & out_ready
- out_data  out  DATA_WIDTH  output beat
- out_last  out  1  last beat of group or single-beat transfer
- err  out  1  one-cycle pulse: group overflow

## Operation
- Swizzle function sw(d, osize_vec): for each set bit k, block i of width W=8·2^k moves to block DATA_WIDTH/W-1-i. Results for all set bits are ORed together. All-zero osize_vec yields 0. Multi-hot yields the OR of selections and is not an error.
- FSM states: IDLE, FILL, DRAIN.
- IDLE handles mode 00 and mode 01 as streaming:
  - in_ready = !out_valid | out_ready.
  - On accept: the output register loads in_data (mode 00) or sw(in_data) (mode 01), and out_last=1.
- IDLE, mode 10 accept:
  - buf[0]=in_data; osize and mode are latched for the group; cnt=1.
  - Next state is DRAIN if in_last, else FILL.
- FILL:
  - in_ready=1. Each accept writes buf[cnt] and increments cnt.
  - in_mode and in_osize_vec are ignored; the latched values apply.
  - On in_last, go to DRAIN.
  - If a beat is accepted with cnt==MAX_BEATS-1 and no in_last, it is forced to be the last beat: err pulses the next cycle, and the state goes to DRAIN.
- DRAIN:
  - in_ready=0.
  - Whenever the output register is free or being emptied this cycle, it loads sw(buf[cnt-1]) and cnt decrements. out_last=1 on the beat from buf[0].
  - After buf[0] is loaded, go to IDLE.
- Output register holds its value while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, err=0, in_ready=0 during reset; FSM=IDLE, cnt=0. in_ready=1 from the first cycle after reset release.
- Modes 00/01:
  - Latency 1 cycle (accept at t, out_valid at t+1).
  - Throughput 1 beat/cycle while out_ready=1.
- Mode 10:
  - Last input accepted at t: DRAIN from t+1, first output beat valid at t+2.
  - N beats drain in N cycles with out_ready=1.
  - The next input is accepted no earlier than the cycle the final output beat loads.
- Backpressure stalls DRAIN without losing or repeating beats. out_data is stable while stalled.
- in_ready never depends combinationally on in_valid. It may depend on out_ready.
- Reset asserted mid-FILL or mid-DRAIN discards the group immediately. No output beats appear after release.

## Test plan
- Mode 01, osize_vec=00001, in_data=128'h0F0E0D0C_0B0A0908_07060504_03020100 -> out_data=128'h00010203_04050607_08090A0B_0C0D0E0F one cycle later, out_last=1.
- Mode 01, osize_vec=00100, same data -> out_data=128'h03020100_07060504_0B0A0908_0F0E0D0C. Also osize_vec=00000 -> out_data=0. Mode 00 -> out_data equal to in_data.
- Mode 10, three beats A=128'h…03020100-pattern, B=A+16 per byte, C=A+32 per byte, byte osize, in_last on C -> outputs sw(C), sw(B), sw(A) on consecutive cycles starting 2 cycles after C is accepted; out_last only on sw(A); in_ready=0 throughout drain.
- Mode 10 with out_ready toggling 1,0,0,1 during drain -> every beat appears exactly once, in order, with out_data stable while stalled.
- Mode 10, 8 beats with no in_last (MAX_BEATS=8) -> err high for exactly one cycle after beat 8 is accepted; 8 reversed beats drain; out_last on the beat from buf[0].
- rst_n pulsed low during DRAIN after 1 of 4 beats emitted -> out_valid=0 immediately; after release, no remaining beats appear; a mode 01 beat accepted next is output correctly with latency 1.
